// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Purpose  : Shared definitions for the memory-mapped UART blocks:
//             CPU-visible register addresses, receive status bit positions,
//             receiver FSM state encoding and the oversampling ratio.
//  Options  : UART_RX_PARITY_EN adds the RX_PARITY state (8E1 frames).
//  Revision : 1.0  initial release
// ============================================================================
package uart_pkg;

    // CPU data-bus addresses of the UART register block
    localparam logic [31:0] UART_TX_CTRL = 32'hF000_0000;
    localparam logic [31:0] UART_TX_DATA = 32'hF000_0001;
    localparam logic [31:0] UART_RX_STAT = 32'hF000_0002;
    localparam logic [31:0] UART_RX_DATA = 32'hF000_0003;

    // Receive status register bit positions
    localparam int STAT_VALID = 0;
    localparam int STAT_OVR   = 1;
    localparam int STAT_FERR  = 2;
    localparam int STAT_FULL  = 3;
    localparam int STAT_PERR  = 4;

    // Oversample ticks per bit period
    localparam int OVERSAMPLE = 4;

    // Receiver state machine
`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_t;
`else
    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_STOP   = 3'd4
    } rx_state_t;
`endif

endpackage : uart_pkg
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo
//  Purpose  : Small single-clock FIFO with extra-MSB pointers. A push while
//             full is ignored unless a pop happens on the same edge, in which
//             case the freed slot takes the new entry.
//  Ports    : clk, rst_n (async, active-low)
//             push / din       - write side
//             pop  / dout      - read side, dout shows the head entry
//             empty / full     - occupancy flags
//  Revision : 1.0  initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_do_pop;
    logic             w_do_push;

    assign empty     = (r_wptr == r_rptr);
    // Same slot index but opposite lap bit: writer is one full lap ahead
    assign full      = (r_wptr[AW] != r_rptr[AW]) &&
                       (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);
    assign dout      = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    // Storage needs no reset: entries are only visible between the pointers
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= din;
    end

endmodule : sync_fifo
`default_nettype wire

// File: rtl/uart_rx_mmio.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_mmio
//  Purpose  : Memory-mapped UART receiver. Deserialises 8N1 frames (8E1 with
//             UART_RX_PARITY_EN defined) from rx into a FIFO and exposes a
//             status register (0xF000_0002) and data register (0xF000_0003)
//             on the CPU load path.
//  Ports    : clk, rst_n    - clock, async active-low reset
//             rx            - serial input, idle high, asynchronous
//             read_enable   - CPU load strobe; qualifies pop / flag clear
//             addr          - CPU data address
//             read_data     - register value, combinational from addr
//             hit           - addr selects one of the two receive registers
//             rx_irq        - high while the FIFO holds data
//  Options  : UART_RX_PARITY_EN - even parity bit checked, status bit4 = perr
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx_mmio
    import uart_pkg::*;
#(
    parameter int CLOCK_DIVIDE = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx,
    input  logic        read_enable,
    input  logic [31:0] addr,
    output logic [31:0] read_data,
    output logic        hit,
    output logic        rx_irq
);

    localparam int DIV_W = (CLOCK_DIVIDE > 1) ? $clog2(CLOCK_DIVIDE) : 1;
    localparam logic [DIV_W-1:0] C_DIV_RELOAD = DIV_W'(CLOCK_DIVIDE - 1);
    localparam logic [1:0]       C_BIT_CNT    = 2'(OVERSAMPLE - 1);
    // Half a bit period: lands the start-bit check in its middle
    localparam logic [1:0]       C_START_CNT  = 2'(OVERSAMPLE / 2 - 1);

    // ---------------- input synchroniser and tick divider -----------------
    logic             r_sync1;
    logic             r_sync2;
    logic [DIV_W-1:0] r_div;
    logic             w_tick;

    rx_state_t        r_state;
    rx_state_t        w_state_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
        end
    end

    // Held at reload in IDLE so the first tick phase is fixed to the start edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= C_DIV_RELOAD;
        end else if (r_state == RX_IDLE || r_div == '0) begin
            r_div <= C_DIV_RELOAD;
        end else begin
            r_div <= r_div - 1'b1;
        end
    end

    assign w_tick = (r_state != RX_IDLE) && (r_div == '0);

    // ---------------- receive FSM -------------------------------------------
    logic [1:0] r_cnt;
    logic [1:0] w_cnt_next;
    logic [2:0] r_bit_idx;
    logic [2:0] w_bit_idx_next;
    logic [7:0] r_shift;
    logic [7:0] w_shift_next;
    logic       w_push;
    logic       w_ferr_set;
`ifdef UART_RX_PARITY_EN
    logic       r_par_bad;
    logic       w_par_bad_next;
    logic       w_perr_set;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= RX_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
`ifdef UART_RX_PARITY_EN
            r_par_bad <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_bit_idx <= w_bit_idx_next;
            r_shift   <= w_shift_next;
`ifdef UART_RX_PARITY_EN
            r_par_bad <= w_par_bad_next;
`endif
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_bit_idx_next = r_bit_idx;
        w_shift_next   = r_shift;
        w_push         = 1'b0;
        w_ferr_set     = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_bad_next = r_par_bad;
        w_perr_set     = 1'b0;
`endif
        case (r_state)
            RX_IDLE: begin
                if (!r_sync2) begin
                    w_state_next = RX_START;
                    w_cnt_next   = C_START_CNT;
                end
            end
            RX_START: begin
                if (w_tick) begin
                    if (r_cnt != '0) begin
                        w_cnt_next = r_cnt - 1'b1;
                    end else if (r_sync2) begin
                        // Line went back high: a glitch, not a start bit
                        w_state_next = RX_IDLE;
                    end else begin
                        w_state_next   = RX_DATA;
                        w_bit_idx_next = '0;
                        w_cnt_next     = C_BIT_CNT;
`ifdef UART_RX_PARITY_EN
                        w_par_bad_next = 1'b0;
`endif
                    end
                end
            end
            RX_DATA: begin
                if (w_tick) begin
                    if (r_cnt != '0) begin
                        w_cnt_next = r_cnt - 1'b1;
                    end else begin
                        // LSB arrives first, so shift in from the top
                        w_shift_next   = {r_sync2, r_shift[7:1]};
                        w_cnt_next     = C_BIT_CNT;
                        w_bit_idx_next = r_bit_idx + 1'b1;
                        if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            w_state_next = RX_PARITY;
`else
                            w_state_next = RX_STOP;
`endif
                        end
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            RX_PARITY: begin
                if (w_tick) begin
                    if (r_cnt != '0) begin
                        w_cnt_next = r_cnt - 1'b1;
                    end else begin
                        // Even parity: the parity bit equals the XOR of the data
                        if (r_sync2 != ^r_shift) begin
                            w_perr_set     = 1'b1;
                            w_par_bad_next = 1'b1;
                        end
                        w_cnt_next   = C_BIT_CNT;
                        w_state_next = RX_STOP;
                    end
                end
            end
`endif
            RX_STOP: begin
                if (w_tick) begin
                    if (r_cnt != '0) begin
                        w_cnt_next = r_cnt - 1'b1;
                    end else begin
                        w_state_next = RX_IDLE;
                        if (r_sync2) begin
`ifdef UART_RX_PARITY_EN
                            w_push = !r_par_bad;
`else
                            w_push = 1'b1;
`endif
                        end else begin
                            w_ferr_set = 1'b1;
                        end
                    end
                end
            end
            default: begin
                w_state_next = RX_IDLE;
            end
        endcase
    end

    // ---------------- FIFO and CPU register interface -----------------------
    logic       w_is_stat;
    logic       w_is_data;
    logic       w_pop;
    logic       w_clr;
    logic       w_ovr_set;
    logic       w_empty;
    logic       w_full;
    logic [7:0] w_fifo_dout;
    logic       r_ovr;
    logic       r_ferr;

    assign w_is_stat = (addr == UART_RX_STAT);
    assign w_is_data = (addr == UART_RX_DATA);
    assign hit       = w_is_stat || w_is_data;
    assign w_pop     = read_enable && w_is_data && !w_empty;
    assign w_clr     = read_enable && w_is_stat;
    // A simultaneous pop frees the slot, so only a push with no pop overflows
    assign w_ovr_set = w_push && w_full && !w_pop;
    assign rx_irq    = !w_empty;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .pop   (w_pop),
        .din   (r_shift),
        .dout  (w_fifo_dout),
        .empty (w_empty),
        .full  (w_full)
    );

    // Sticky flags: a set on the same edge as a status-read clear wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovr  <= 1'b0;
            r_ferr <= 1'b0;
        end else begin
            r_ovr  <= w_ovr_set  || (r_ovr  && !w_clr);
            r_ferr <= w_ferr_set || (r_ferr && !w_clr);
        end
    end

`ifdef UART_RX_PARITY_EN
    logic r_perr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perr <= 1'b0;
        end else begin
            r_perr <= w_perr_set || (r_perr && !w_clr);
        end
    end
`endif

    always_comb begin
        read_data = '0;
        if (w_is_stat) begin
            read_data[STAT_VALID] = !w_empty;
            read_data[STAT_OVR]   = r_ovr;
            read_data[STAT_FERR]  = r_ferr;
            read_data[STAT_FULL]  = w_full;
`ifdef UART_RX_PARITY_EN
            read_data[STAT_PERR]  = r_perr;
`endif
        end else if (w_is_data && !w_empty) begin
            read_data[7:0] = w_fifo_dout;
        end
    end

endmodule : uart_rx_mmio
`default_nettype wire

// File: tb/tb_uart_rx_mmio.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx_mmio
//  Purpose  : Self-checking bench for uart_rx_mmio (CLOCK_DIVIDE=1, depth 4).
//             A queue-based model predicts FIFO contents and sticky flags from
//             the frames sent and the CPU reads issued; outputs are compared
//             to it every cycle, and directed cases pin literal values.
//  Options  : UART_RX_PARITY_EN selects 8E1 frames
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_rx_mmio;

    localparam int DEPTH = 4;
    localparam logic [31:0] A_TXC  = 32'hF000_0000;
    localparam logic [31:0] A_TXD  = 32'hF000_0001;
    localparam logic [31:0] A_STAT = 32'hF000_0002;
    localparam logic [31:0] A_DATA = 32'hF000_0003;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    // One bit = 4 clocks. The line is sampled in the last part of each bit,
    // seen through a 2-flop synchroniser: measured from the first edge that
    // sees the start bit (edge_cnt+1), the stop bit is judged 40 edges later
    // (44 with a parity bit); the parity bit 4 edges before that.
    localparam int NBITS    = PAR_EN ? 11 : 10;
    localparam int STOP_OFS = PAR_EN ? 45 : 41;
    localparam int PAR_OFS  = 41;

    localparam int EV_PUSH = 0;
    localparam int EV_FERR = 1;
    localparam int EV_PERR = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx = 1'b1;
    logic        read_enable = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] read_data;
    logic        hit;
    logic        rx_irq;

    uart_rx_mmio #(
        .CLOCK_DIVIDE (1),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx          (rx),
        .read_enable (read_enable),
        .addr        (addr),
        .read_data   (read_data),
        .hit         (hit),
        .rx_irq      (rx_irq)
    );

    always #5 clk = ~clk;

    // ---------------- model -------------------------------------------------
    typedef struct {
        int         at;
        int         kind;
        logic [7:0] b;
    } ev_t;

    ev_t        ev_q[$];
    logic [7:0] m_q[$];
    logic       m_ovr = 1'b0;
    logic       m_ferr = 1'b0;
    logic       m_perr = 1'b0;
    int         edge_cnt = 0;
    int         n_checks = 0;
    int         n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (clk) edge_cnt++;
            if (!rst_n) begin
                m_q.delete();
                ev_q.delete();
                m_ovr  = 1'b0;
                m_ferr = 1'b0;
                m_perr = 1'b0;
            end else begin
                if (read_enable && addr == A_STAT) begin
                    m_ovr  = 1'b0;
                    m_ferr = 1'b0;
                    m_perr = 1'b0;
                end
                if (read_enable && addr == A_DATA && m_q.size() != 0)
                    void'(m_q.pop_front());
                while (ev_q.size() != 0 && ev_q[0].at <= edge_cnt) begin
                    ev_t e;
                    e = ev_q.pop_front();
                    if (e.kind == EV_PUSH) begin
                        if (m_q.size() < DEPTH) m_q.push_back(e.b);
                        else                    m_ovr = 1'b1;
                    end else if (e.kind == EV_FERR) begin
                        m_ferr = 1'b1;
                    end else begin
                        m_perr = 1'b1;
                    end
                end
            end
        end
    end

    // Every-cycle comparison against the model
    initial begin
        forever begin
            logic [31:0] e;
            @(negedge clk);
            #1;
            e = 32'h0;
            if (addr == A_STAT)
                e = {27'b0, m_perr, (m_q.size() == DEPTH), m_ferr, m_ovr, (m_q.size() != 0)};
            else if (addr == A_DATA && m_q.size() != 0)
                e = {24'b0, m_q[0]};
            check("read_data", read_data, e);
            check("hit", {31'b0, hit}, {31'b0, (addr == A_STAT || addr == A_DATA)});
            check("rx_irq", {31'b0, rx_irq}, {31'b0, (m_q.size() != 0)});
        end
    end

    // ---------------- stimulus helpers (all start just after a negedge) -----
    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit par_ok,
                              input bit pop_at_push, input int abort_bit);
        logic [10:0] fr;
        int          k;
        k = edge_cnt;
        if (abort_bit < 0) begin
            if (PAR_EN && !par_ok) ev_q.push_back('{k + PAR_OFS, EV_PERR, b});
            if (!stop_ok)                  ev_q.push_back('{k + STOP_OFS, EV_FERR, b});
            else if (!PAR_EN || par_ok)    ev_q.push_back('{k + STOP_OFS, EV_PUSH, b});
        end
        fr      = '1;
        fr[0]   = 1'b0;
        fr[8:1] = b;
        fr[9]   = PAR_EN ? ((^b) ^ !par_ok) : stop_ok;
        fr[10]  = stop_ok;
        for (int i = 0; i < NBITS; i++) begin
            if (abort_bit >= 0 && i == abort_bit + 1) begin
                rst_n = 1'b0;
                rx    = 1'b1;
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                repeat (8) @(negedge clk);
                return;
            end
            rx = fr[i];
            repeat (4) @(negedge clk);
        end
        rx = 1'b1;
        if (pop_at_push) begin
            read_enable = 1'b1;
            addr        = A_DATA;
            @(negedge clk);
            read_enable = 1'b0;
            addr        = A_TXC;
        end
        repeat (8 + $urandom_range(0, 4)) @(negedge clk);
    endtask

    task automatic cpu_read(input logic [31:0] a, output logic [31:0] v);
        read_enable = 1'b1;
        addr        = a;
        #1 v = read_data;
        @(negedge clk);
        read_enable = 1'b0;
        addr        = A_TXC;
    endtask

    task automatic peek(input logic [31:0] a, output logic [31:0] v, output logic irq);
        addr = a;
        #1;
        v   = read_data;
        irq = rx_irq;
        @(negedge clk);
    endtask

    task automatic random_reader(input int cycles, input int rate);
        for (int i = 0; i < cycles; i++) begin
            if ($urandom_range(0, 31) < rate) begin
                read_enable = 1'b1;
                addr        = $urandom_range(0, 1) ? A_STAT : A_DATA;
            end else begin
                read_enable = 1'b0;
                case ($urandom_range(0, 4))
                    0:       addr = A_STAT;
                    1:       addr = A_DATA;
                    2:       addr = A_TXC;
                    3:       addr = A_TXD;
                    default: addr = $urandom;
                endcase
            end
            @(negedge clk);
        end
        read_enable = 1'b0;
        addr        = A_TXC;
    endtask

    // ---------------- directed + random sequence ----------------------------
    initial begin
        logic [31:0] v;
        logic        irq;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        peek(A_STAT, v, irq);
        check("reset status", v, 32'h0);
        check("reset irq", {31'b0, irq}, 32'h0);

        // Clean 0xA5
        send_frame(8'hA5, 1'b1, 1'b1, 1'b0, -1);
        peek(A_STAT, v, irq);
        check("A5 status", v, 32'h1);
        check("A5 irq", {31'b0, irq}, 32'h1);
        cpu_read(A_DATA, v);
        check("A5 data", v, 32'h0000_00A5);
        peek(A_STAT, v, irq);
        check("A5 status after pop", v, 32'h0);
        check("A5 irq after pop", {31'b0, irq}, 32'h0);

        // One-clock low glitch
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (12) @(negedge clk);
        peek(A_STAT, v, irq);
        check("glitch status", v, 32'h0);

        // Framing error on 0x3C
        send_frame(8'h3C, 1'b0, 1'b1, 1'b0, -1);
        peek(A_STAT, v, irq);
        check("ferr status", v, 32'h4);
        cpu_read(A_STAT, v);
        check("ferr status read", v, 32'h4);
        peek(A_STAT, v, irq);
        check("ferr cleared", v, 32'h0);

        // Overflow: five bytes into a four-entry FIFO
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b1, 1'b0, -1);
        peek(A_STAT, v, irq);
        check("ovr status full", v, 32'hB);
        for (int i = 1; i <= 4; i++) begin
            cpu_read(A_DATA, v);
            check("ovr data", v, 32'(i));
        end
        peek(A_STAT, v, irq);
        check("ovr status drained", v, 32'h2);
        cpu_read(A_STAT, v);

        // Pop on the same edge as the push into a full FIFO
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, 1'b1, 1'b0, -1);
        send_frame(8'h05, 1'b1, 1'b1, 1'b1, -1);
        peek(A_STAT, v, irq);
        check("pop+push status", v, 32'h9);
        for (int i = 2; i <= 5; i++) begin
            cpu_read(A_DATA, v);
            check("pop+push data", v, 32'(i));
        end
        peek(A_STAT, v, irq);
        check("pop+push empty", v, 32'h0);

        // Reset during the data bits of 0x55, then a clean 0x77
        send_frame(8'h55, 1'b1, 1'b1, 1'b0, 3);
        peek(A_STAT, v, irq);
        check("abort status", v, 32'h0);
        check("abort irq", {31'b0, irq}, 32'h0);
        send_frame(8'h77, 1'b1, 1'b1, 1'b0, -1);
        cpu_read(A_DATA, v);
        check("after abort data", v, 32'h77);

        if (PAR_EN) begin
            send_frame(8'h07, 1'b1, 1'b0, 1'b0, -1);
            peek(A_STAT, v, irq);
            check("parity status", v, 32'h10);
            cpu_read(A_STAT, v);
        end

        // Randomised frames with concurrent random CPU reads
        for (int n = 0; n < 150; n++) begin
            logic [7:0] b;
            bit         s_ok;
            bit         p_ok;
            int         rate;
            b    = 8'($urandom);
            s_ok = ($urandom_range(0, 7) != 0);
            p_ok = ($urandom_range(0, 7) != 0);
            rate = $urandom_range(0, 3);
            fork
                send_frame(b, s_ok, p_ok, 1'b0, -1);
                random_reader(NBITS * 4, rate);
            join
        end

        for (int i = 0; i <= DEPTH; i++) cpu_read(A_DATA, v);
        cpu_read(A_STAT, v);
        peek(A_STAT, v, irq);
        check("final status", v, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_uart_rx_mmio
`default_nettype wire
